data_memory_ctrl: RTL and testbench

- Parametrised, byte-addressable synchronous data memory with a request/response handshake.
- Serves load/store units for byte, half-word and word accesses, with sign/zero extension on loads and byte-lane masking on stores.
- Supports configurable depth and read latency.
- Detects out-of-range, illegal-size and (optionally) misaligned accesses and reports them as faults instead of corrupting memory.

---
 rtl/data_memory_pkg.sv | 17 +
 rtl/data_memory_ctrl_mem_lane_align.sv | 26 ++
 rtl/data_memory_ctrl.sv | 79 +++++++
 tb/tb_data_memory_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// data_memory_pkg: size codes, FSM state encoding and size legality for data_memory_ctrl.
package data_memory_pkg;
   localparam logic [2:0] DATA_SIZE_BYTE        = 3'b000;
   localparam logic [2:0] DATA_SIZE_HALF_WORD   = 3'b001;
   localparam logic [2:0] DATA_SIZE_WORD        = 3'b010;
   localparam logic [2:0] DATA_SIZE_U_BYTE      = 3'b100;
   localparam logic [2:0] DATA_SIZE_U_HALF_WORD = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   function automatic logic is_legal_size(input logic [2:0] s);
      return s inside {DATA_SIZE_BYTE, DATA_SIZE_HALF_WORD, DATA_SIZE_WORD,
                       DATA_SIZE_U_BYTE, DATA_SIZE_U_HALF_WORD};
   endfunction
endpackage

// File: rtl/data_memory_ctrl_mem_lane_align.sv
// mem_lane_align: store lane shift / byte enables and load lane select with sign/zero extension.
module mem_lane_align
   import data_memory_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [31:0] wdata_sh,
   output logic [3:0]  be,
   output logic [31:0] rdata_ext
);
   logic [1:0]  lane;
   logic [31:0] rsh;
   logic        sgn;
   // half/word offsets are aligned down; misaligned trapping is decided by the top
   always_comb begin
      lane      = size[1:0] == 2'b00 ? offset : size[1:0] == 2'b01 ? {offset[1], 1'b0} : 2'b00;
      wdata_sh  = wdata << {lane, 3'b000};
      be        = size[1:0] == 2'b00 ? 4'b0001 << lane : size[1:0] == 2'b01 ? 4'b0011 << lane : 4'b1111;
      rsh       = rword >> {lane, 3'b000};
      sgn       = ~size[2];
      rdata_ext = size[1:0] == 2'b00 ? {{24{sgn & rsh[7]}}, rsh[7:0]} :
                  size[1:0] == 2'b01 ? {{16{sgn & rsh[15]}}, rsh[15:0]} : rsh;
   end
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable data memory with req/resp handshake and fault reporting.
// Define DATA_MEMORY_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning down.
module data_memory_ctrl
   import data_memory_pkg::*;
#(
   parameter int DEPTH_WORDS  = 256,
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  size_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        fault_o
);
   localparam int ADDR_W = $clog2(DEPTH_WORDS);

   logic [31:0]       mem [DEPTH_WORDS];
   logic [1:0]        state;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       wdata_sh, rdata_ext, result, pend_data;
   logic [3:0]        be;
   logic              acc, mis, fault, fault_r, pend_fault;

   assign idx      = addr_i[ADDR_W+1:2];
   assign ready_o  = state != ST_WAIT;
   assign rvalid_o = state == ST_RESP;
   assign fault_o  = rvalid_o && fault_r;
   assign acc      = req_i && ready_o;
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
   assign mis = (size_i[1:0] == 2'b01 && addr_i[0]) || (size_i == DATA_SIZE_WORD && addr_i[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif
   assign fault  = |addr_i[31:ADDR_W+2] || !is_legal_size(size_i) || mis;
   assign result = (we_i || fault) ? 32'h0 : rdata_ext;

   mem_lane_align u_align (
      .size      (size_i),
      .offset    (addr_i[1:0]),
      .wdata     (wdata_i),
      .rword     (mem[idx]),
      .wdata_sh  (wdata_sh),
      .be        (be),
      .rdata_ext (rdata_ext)
   );

   always_ff @(posedge clk)
      if (acc && we_i && !fault)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];

   // at latency 2 the result waits in pend_* during WAIT so rdata_o holds until the next response
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= ST_IDLE;
         rdata_o    <= 32'h0;
         fault_r    <= 1'b0;
         pend_data  <= 32'h0;
         pend_fault <= 1'b0;
      end else begin
         state <= acc ? (READ_LATENCY == 1 ? ST_RESP : ST_WAIT) : state == ST_WAIT ? ST_RESP : ST_IDLE;
         if (acc && READ_LATENCY == 1) begin
            rdata_o <= result;
            fault_r <= fault;
         end else if (acc) begin
            pend_data  <= result;
            pend_fault <= fault;
         end else if (state == ST_WAIT) begin
            rdata_o <= pend_data;
            fault_r <= pend_fault;
         end
      end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed table + random model-checked bench for latency-1 and latency-2 instances.
module tb_data_memory_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req1 = 0, we1 = 0, req2 = 0, we2 = 0;
   logic [2:0]  size1 = 0, size2 = 0;
   logic [31:0] addr1 = 0, wdata1 = 0, addr2 = 0, wdata2 = 0;
   logic        ready1, rvalid1, fault1, ready2, rvalid2, fault2;
   logic [31:0] rdata1, rdata2;
   int          checks = 0, errors = 0;
   logic [7:0]  mm [1024];

   typedef struct {
      logic        we;
      logic [2:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] d;
      logic        f;
   } vec_t;
   vec_t tbl [16];

   always #5 clk = ~clk;

   data_memory_ctrl #(.DEPTH_WORDS(256), .READ_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .req_i(req1), .we_i(we1), .size_i(size1), .addr_i(addr1),
      .wdata_i(wdata1), .ready_o(ready1), .rvalid_o(rvalid1), .rdata_o(rdata1), .fault_o(fault1));

   data_memory_ctrl #(.DEPTH_WORDS(256), .READ_LATENCY(2)) dut2 (
      .clk(clk), .rst(rst), .req_i(req2), .we_i(we2), .size_i(size2), .addr_i(addr2),
      .wdata_i(wdata2), .ready_o(ready2), .rvalid_o(rvalid2), .rdata_o(rdata2), .fault_o(fault2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // byte-level reference: accesses of n bytes starting at the aligned-down address
   task automatic model(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] d, output logic f);
      int n;
      logic [31:0] base, v;
      n    = sz[1:0] == 2'd0 ? 1 : sz[1:0] == 2'd1 ? 2 : 4;
      base = a - (a % n);
      f    = !(sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || a >= 32'd1024;
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
      f = f || base != a;
`endif
      d = 0;
      if (!f) begin
         if (we) for (int k = 0; k < n; k++) mm[base[9:0] + 10'(k)] = wd[8*k +: 8];
         else begin
            v = 0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = mm[base[9:0] + 10'(k)];
            if (!sz[2] && n == 1 && v[7]) v[31:8] = '1;
            if (!sz[2] && n == 2 && v[15]) v[31:16] = '1;
            d = v;
         end
      end
   endtask

   task automatic access1(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] ed, input logic ef);
      @(negedge clk);
      req1 = 1; we1 = we; size1 = sz; addr1 = a; wdata1 = wd;
      @(posedge clk); #1;
      req1 = 0;
      chk($sformatf("rvalid1 @%h", a), 32'(rvalid1), 32'd1);
      chk($sformatf("rdata1 @%h sz%0d we%0d", a, sz, we), rdata1, ed);
      chk($sformatf("fault1 @%h sz%0d", a, sz), 32'(fault1), 32'(ef));
   endtask

   task automatic access2(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] ed, input logic ef);
      @(negedge clk);
      req2 = 1; we2 = we; size2 = sz; addr2 = a; wdata2 = wd;
      @(posedge clk); #1;
      req2 = 0;
      chk("rvalid2 in wait", 32'(rvalid2), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("rvalid2 @%h", a), 32'(rvalid2), 32'd1);
      chk($sformatf("rdata2 @%h", a), rdata2, ed);
      chk($sformatf("fault2 @%h", a), 32'(fault2), 32'(ef));
   endtask

   initial begin
      logic [31:0] d, a, wd;
      logic        f, we;
      logic [2:0]  sz;
      tbl[0]  = '{1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
      tbl[1]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b1, 3'd0, 32'h13,  32'h00000080, 32'h0,        1'b0};
      tbl[3]  = '{1'b0, 3'd0, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0};
      tbl[4]  = '{1'b0, 3'd4, 32'h13,  32'h0,        32'h00000080, 1'b0};
      tbl[5]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0};
      tbl[6]  = '{1'b1, 3'd2, 32'h20,  32'h11223344, 32'h0,        1'b0};
      tbl[7]  = '{1'b1, 3'd1, 32'h22,  32'h00008001, 32'h0,        1'b0};
      tbl[8]  = '{1'b0, 3'd1, 32'h22,  32'h0,        32'hFFFF8001, 1'b0};
      tbl[9]  = '{1'b0, 3'd5, 32'h22,  32'h0,        32'h00008001, 1'b0};
      tbl[10] = '{1'b0, 3'd2, 32'h20,  32'h0,        32'h80013344, 1'b0};
      tbl[11] = '{1'b1, 3'd7, 32'h20,  32'hFFFFFFFF, 32'h0,        1'b1};
      tbl[12] = '{1'b1, 3'd2, 32'h400, 32'hFFFFFFFF, 32'h0,        1'b1};
      tbl[13] = '{1'b0, 3'd2, 32'h20,  32'h0,        32'h80013344, 1'b0};
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
      tbl[14] = '{1'b0, 3'd1, 32'h11,  32'h0,        32'h0,        1'b1};
      tbl[15] = '{1'b1, 3'd2, 32'h13,  32'h0,        32'h0,        1'b1};
`else
      tbl[14] = '{1'b0, 3'd1, 32'h11,  32'h0,        32'hFFFFBEEF, 1'b0};
      tbl[15] = '{1'b1, 3'd2, 32'h13,  32'h0,        32'h0,        1'b0};
`endif
      repeat (2) @(negedge clk);
      chk("reset ready", 32'(ready1), 32'd1);
      chk("reset rvalid", 32'(rvalid1), 32'd0);
      chk("reset rdata", rdata1, 32'd0);
      chk("reset fault", 32'(fault1), 32'd0);
      rst = 0;
      for (int i = 0; i < 256; i++) begin
         wd = $urandom;
         model(1'b1, 3'd2, 32'(i * 4), wd, d, f);
         access1(1'b1, 3'd2, 32'(i * 4), wd, d, f);
      end
      for (int i = 0; i < 16; i++) begin
         model(tbl[i].we, tbl[i].sz, tbl[i].a, tbl[i].wd, d, f);
         access1(tbl[i].we, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].d, tbl[i].f);
      end
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
      access1(1'b0, 3'd2, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
`else
      access1(1'b0, 3'd2, 32'h10, 32'h0, 32'h0, 1'b0);
`endif
      // read-after-write with the request held across back-to-back accepts
      @(negedge clk);
      req1 = 1; we1 = 1; size1 = 3'd0; addr1 = 32'h31; wdata1 = 32'h5A;
      @(negedge clk);
      we1 = 0; size1 = 3'd4;
      chk("b2b ready1", 32'(ready1), 32'd1);
      @(posedge clk); #1;
      req1 = 0;
      chk("raw rvalid", 32'(rvalid1), 32'd1);
      chk("raw rdata", rdata1, 32'h5A);
      model(1'b1, 3'd0, 32'h31, 32'h5A, d, f);
      for (int i = 0; i < 300; i++) begin
         we = 1'($urandom);
         sz = 3'($urandom);
         a  = ($urandom_range(0, 9) == 0) ? (32'h400 | $urandom) : 32'($urandom_range(0, 1023));
         wd = $urandom;
         model(we, sz, a, wd, d, f);
         access1(we, sz, a, wd, d, f);
      end
      // latency 2: held requests alternate ready 1/0
      @(negedge clk);
      req2 = 1; we2 = 1; size2 = 3'd2; addr2 = 32'h40; wdata2 = 32'hCAFEF00D;
      chk("l2 ready idle", 32'(ready2), 32'd1);
      @(negedge clk);
      chk("l2 ready wait", 32'(ready2), 32'd0);
      chk("l2 rvalid wait", 32'(rvalid2), 32'd0);
      we2 = 0;
      @(negedge clk);
      chk("l2 ready resp", 32'(ready2), 32'd1);
      chk("l2 rvalid resp", 32'(rvalid2), 32'd1);
      chk("l2 store rdata", rdata2, 32'd0);
      chk("l2 store fault", 32'(fault2), 32'd0);
      @(negedge clk);
      req2 = 0;
      chk("l2 ready wait2", 32'(ready2), 32'd0);
      chk("l2 rvalid wait2", 32'(rvalid2), 32'd0);
      @(negedge clk);
      chk("l2 load rvalid", 32'(rvalid2), 32'd1);
      chk("l2 load rdata", rdata2, 32'hCAFEF00D);
      @(negedge clk);
      chk("l2 idle rvalid", 32'(rvalid2), 32'd0);
      chk("l2 rdata hold", rdata2, 32'hCAFEF00D);
      access2(1'b0, 3'd7, 32'h40, 32'h0, 32'h0, 1'b1);
      access2(1'b0, 3'd4, 32'h40, 32'h0, 32'h0D, 1'b0);
      // reset during WAIT drops the response but keeps a committed store
      @(negedge clk);
      req2 = 1; we2 = 1; size2 = 3'd2; addr2 = 32'h44; wdata2 = 32'h12345678;
      @(negedge clk);
      req2 = 0;
      chk("pre-rst ready2", 32'(ready2), 32'd0);
      #2 rst = 1;
      #1;
      chk("rst ready2", 32'(ready2), 32'd1);
      chk("rst rvalid2", 32'(rvalid2), 32'd0);
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post-rst rvalid2", 32'(rvalid2), 32'd0);
      end
      access2(1'b0, 3'd2, 32'h44, 32'h0, 32'h12345678, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
